// File: rtl/color_convert_inv_ycc2rgb.sv
// YCbCr 4:4:4 -> RGB inverse colour converter.
// Three-stage valid/ready pipeline that stalls as a whole and carries an end-of-line flag through.
module color_convert_inv_ycc2rgb #(
   parameter int COEF_FRAC = 8,
   parameter int C_RCR     = 359,
   parameter int C_GCB     = 88,
   parameter int C_GCR     = 183,
   parameter int C_BCB     = 454
) (
   input  logic        ap_clk,
   input  logic        ap_rst,
   input  logic [23:0] s_ycc_data,
   input  logic        s_ycc_last,
   input  logic        s_ycc_valid,
   output logic        s_ycc_ready,
   output logic [23:0] m_rgb_data,
   output logic        m_rgb_last,
   output logic        m_rgb_valid,
   input  logic        m_rgb_ready
);

   // Coefficients gain a zero sign bit so the multiply stays signed x unsigned.
   localparam logic signed [9:0]  K_RCR = 10'(C_RCR);
   localparam logic signed [9:0]  K_GCB = 10'(C_GCB);
   localparam logic signed [9:0]  K_GCR = 10'(C_GCR);
   localparam logic signed [9:0]  K_BCB = 10'(C_BCB);
   localparam logic signed [18:0] HALF  = 19'(2 ** (COEF_FRAC - 1));

   logic en;

   logic               v1_q, last1_q;
   logic signed [9:0]  y1_q;
   logic signed [8:0]  dcb1_q, dcr1_q;
   logic signed [9:0]  y_d;
   logic signed [8:0]  dcb_d, dcr_d;

   logic               v2_q, last2_q;
   logic signed [9:0]  y2_q;
   logic signed [17:0] pr2_q, pgb2_q, pgr2_q, pb2_q;
   logic signed [17:0] pr_d, pgb_d, pgr_d, pb_d;

   logic               v3_q, last3_q;
   logic [23:0]        rgb3_q;
   logic [23:0]        rgb_d;
   logic signed [18:0] y_ext, t_r, t_g, t_b, sum_r, sum_g, sum_b;

   function automatic logic [7:0] clamp8(input logic signed [18:0] v);
      if (v < 0) return 8'd0;
      if (v > 19'sd255) return 8'hFF;
      return v[7:0];
   endfunction

   assign en          = !v3_q || m_rgb_ready;
   assign s_ycc_ready = en;
   assign m_rgb_valid = v3_q;
   assign m_rgb_data  = rgb3_q;
   assign m_rgb_last  = last3_q;

   always_comb begin
      y_d   = {2'b00, s_ycc_data[7:0]};
      dcb_d = $signed({1'b0, s_ycc_data[15:8]})  - 9'sd128;
      dcr_d = $signed({1'b0, s_ycc_data[23:16]}) - 9'sd128;

      pr_d  = 18'(dcr1_q * K_RCR);
      pgb_d = 18'(dcb1_q * K_GCB);
      pgr_d = 18'(dcr1_q * K_GCR);
      pb_d  = 18'(dcb1_q * K_BCB);

      // Rounding offset then arithmetic shift gives floor on negative sums.
      y_ext = 19'(y2_q);
      t_r   = 19'(pr2_q) + HALF;
      t_g   = HALF - 19'(pgb2_q) - 19'(pgr2_q);
      t_b   = 19'(pb2_q) + HALF;
      sum_r = y_ext + (t_r >>> COEF_FRAC);
      sum_g = y_ext + (t_g >>> COEF_FRAC);
      sum_b = y_ext + (t_b >>> COEF_FRAC);
      rgb_d = {clamp8(sum_b), clamp8(sum_g), clamp8(sum_r)};
   end

   always_ff @(posedge ap_clk or posedge ap_rst) begin
      if (ap_rst) begin
         v1_q    <= 1'b0;
         last1_q <= 1'b0;
         y1_q    <= '0;
         dcb1_q  <= '0;
         dcr1_q  <= '0;
         v2_q    <= 1'b0;
         last2_q <= 1'b0;
         y2_q    <= '0;
         pr2_q   <= '0;
         pgb2_q  <= '0;
         pgr2_q  <= '0;
         pb2_q   <= '0;
         v3_q    <= 1'b0;
         last3_q <= 1'b0;
         rgb3_q  <= '0;
      end else if (en) begin
         v1_q    <= s_ycc_valid && s_ycc_ready;
         last1_q <= s_ycc_last;
         y1_q    <= y_d;
         dcb1_q  <= dcb_d;
         dcr1_q  <= dcr_d;
         v2_q    <= v1_q;
         last2_q <= last1_q;
         y2_q    <= y1_q;
         pr2_q   <= pr_d;
         pgb2_q  <= pgb_d;
         pgr2_q  <= pgr_d;
         pb2_q   <= pb_d;
         v3_q    <= v2_q;
         last3_q <= last2_q;
         rgb3_q  <= rgb_d;
      end
   end

endmodule
